// File: rtl/mips_execute_mul_div.sv
// Iterative HI/LO multiply/divide unit for the MIPS execute stage.
// One product/quotient bit per cycle, with a sign-fixup cycle that commits HI/LO.
module mips_execute_mul_div #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             resetN,
  input  logic             opValid,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] data1,
  input  logic [WIDTH-1:0] data2,
  input  logic             flush,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, FIXUP} state_t;

  state_t             r_state, w_next;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH:0]     r_rem;
  logic [WIDTH-1:0]   r_a, r_b;
  logic               r_div, r_sa, r_sb, r_dz, r_done;
  logic [WIDTH-1:0]   r_hi, r_lo;

  function automatic logic [WIDTH-1:0] f_mag(input logic signed [WIDTH-1:0] v, input logic sgn);
    return (sgn && v[WIDTH-1]) ? WIDTH'(-v) : WIDTH'(v);
  endfunction

  logic               w_accept, w_muldiv, w_mthi, w_mtlo, w_signed, w_dz, w_commit;
  logic [WIDTH:0]     w_madd, w_shift, w_diff;
  logic               w_qbit;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quo, w_remd, w_fix_hi, w_fix_lo;

  assign w_accept = opValid && !busy && !flush;
  assign w_muldiv = w_accept && !op[2];
  assign w_mthi   = w_accept && (op == 3'd4);
  assign w_mtlo   = w_accept && (op == 3'd5);
  assign w_signed = !op[0];
  assign w_dz     = op[1] && (data2 == '0);
  assign w_commit = (r_state == FIXUP) && !flush;

  // Multiply step: add multiplicand into the upper half when the multiplier LSB is set, then shift right.
  assign w_madd  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_a} : '0);
  // Restoring divide step: the borrow out of bit WIDTH means the trial subtraction failed.
  assign w_shift = {r_rem[WIDTH-1:0], r_acc[WIDTH-1]};
  assign w_diff  = w_shift - {1'b0, r_b};
  assign w_qbit  = !w_diff[WIDTH];

  assign w_prod  = (r_sa ^ r_sb) ? -r_acc : r_acc;
  assign w_quo   = (r_sa ^ r_sb) ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
  assign w_remd  = r_sa ? -r_rem[WIDTH-1:0] : r_rem[WIDTH-1:0];

  always_comb begin
    w_fix_hi = w_prod[2*WIDTH-1:WIDTH];
    w_fix_lo = w_prod[WIDTH-1:0];
    if (r_dz) begin
      w_fix_hi = r_a;
      w_fix_lo = '1;
    end else if (r_div) begin
      w_fix_hi = w_remd;
      w_fix_lo = w_quo;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_muldiv) w_next = w_dz ? FIXUP : RUN;
      RUN:     if (flush) w_next = IDLE;
               else if (r_cnt == CW'(WIDTH - 1)) w_next = FIXUP;
      FIXUP:   w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_done  <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      r_state <= w_next;
      r_done  <= w_commit;
      if (w_muldiv)           r_cnt <= '0;
      else if (r_state == RUN) r_cnt <= r_cnt + 1'b1;
      if (w_commit) begin
        r_hi <= w_fix_hi;
        r_lo <= w_fix_lo;
      end else begin
        if (w_mthi) r_hi <= data1;
        if (w_mtlo) r_lo <= data1;
      end
    end
  end

  // Datapath operands and accumulators carry no reset; they are loaded on acceptance.
  always_ff @(posedge clock) begin
    if (w_muldiv) begin
      r_a   <= w_dz ? data1 : f_mag(data1, w_signed);
      r_b   <= f_mag(data2, w_signed);
      r_sa  <= w_signed && data1[WIDTH-1];
      r_sb  <= w_signed && data2[WIDTH-1];
      r_div <= op[1];
      r_dz  <= w_dz;
      r_acc <= {{WIDTH{1'b0}}, (op[1] ? f_mag(data1, w_signed) : f_mag(data2, w_signed))};
      r_rem <= '0;
    end else if (r_state == RUN) begin
      if (r_div) begin
        r_rem <= w_qbit ? w_diff : w_shift;
        r_acc <= {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-2:0], w_qbit};
      end else begin
        r_acc <= {w_madd, r_acc[WIDTH-1:1]};
      end
    end
  end

  assign busy   = (r_state != IDLE);
  assign stall  = opValid && busy && !flush;
  assign done   = r_done;
  assign hi     = r_hi;
  assign lo     = r_lo;
  assign result = (op == 3'd6) ? r_hi : r_lo;

endmodule

// File: tb/tb_mips_execute_mul_div.sv
// Directed-vector bench for mips_execute_mul_div with hand-computed HI/LO results.
module tb_mips_execute_mul_div;

  logic        clock = 1'b0;
  logic        resetN = 1'b0;
  logic        opValid = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] data1 = '0;
  logic [31:0] data2 = '0;
  logic        flush = 1'b0;
  logic        stall, busy, done;
  logic [31:0] result, hi, lo;

  int n_checks = 0;
  int n_errors = 0;

  mips_execute_mul_div #(.WIDTH(32)) dut (
    .clock(clock), .resetN(resetN), .opValid(opValid), .op(op),
    .data1(data1), .data2(data2), .flush(flush), .stall(stall),
    .busy(busy), .done(done), .result(result), .hi(hi), .lo(lo)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue a mult/div, count busy cycles up to done, then check HI/LO and the one-cycle done pulse.
  task automatic do_md(input string tag, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input int ecyc, input logic [31:0] ehi, input logic [31:0] elo);
    int n;
    n = 0;
    @(negedge clock);
    opValid = 1'b1; op = o; data1 = a; data2 = b;
    @(negedge clock);
    opValid = 1'b0;
    while (busy && n < 200) begin
      n++;
      @(negedge clock);
    end
    chk({tag, "_cycles"}, 32'(n), 32'(ecyc));
    chk({tag, "_done"}, {31'd0, done}, 32'd1);
    chk({tag, "_hi"}, hi, ehi);
    chk({tag, "_lo"}, lo, elo);
    @(negedge clock);
    chk({tag, "_done_end"}, {31'd0, done}, 32'd0);
  endtask

  task automatic do_mt(input logic [2:0] o, input logic [31:0] a);
    @(negedge clock);
    opValid = 1'b1; op = o; data1 = a;
    @(negedge clock);
    opValid = 1'b0;
  endtask

  initial begin
    int n;
    logic seen_done;

    #2;
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    @(negedge clock);
    resetN = 1'b1;

    do_md("multu_max", 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 33, 32'hFFFFFFFE, 32'h00000001);
    do_md("mult_neg",  3'd0, 32'hFFFFFFFD, 32'd7,        33, 32'hFFFFFFFF, 32'hFFFFFFEB);
    do_md("div_neg",   3'd2, 32'hFFFFFFF9, 32'd2,        33, 32'hFFFFFFFF, 32'hFFFFFFFD);
    do_md("div_ovf",   3'd2, 32'h80000000, 32'hFFFFFFFF, 33, 32'h00000000, 32'h80000000);
    do_md("divu",      3'd3, 32'd100,      32'd7,        33, 32'd2,        32'd14);
    do_md("divu_z",    3'd3, 32'd5,        32'd0,        1,  32'd5,        32'hFFFFFFFF);
    do_md("div_z",     3'd2, 32'hFFFFFFF0, 32'd0,        1,  32'hFFFFFFF0, 32'hFFFFFFFF);

    // MFLO right behind a MULT stalls until the done cycle.
    @(negedge clock);
    opValid = 1'b1; op = 3'd0; data1 = 32'd3; data2 = 32'd4;
    @(negedge clock);
    op = 3'd7;
    n = 0;
    while (stall && n < 200) begin
      n++;
      @(negedge clock);
    end
    chk("mf_stall_cycles", 32'(n), 32'd33);
    chk("mf_result", result, 32'd12);
    chk("mf_done", {31'd0, done}, 32'd1);
    opValid = 1'b0;

    do_mt(3'd4, 32'h0000AAAA);
    chk("mthi", hi, 32'h0000AAAA);
    opValid = 1'b1; op = 3'd6;
    #1;
    chk("mfhi_stall", {31'd0, stall}, 32'd0);
    chk("mfhi_result", result, 32'h0000AAAA);
    opValid = 1'b0;

    // Flush a MULT at RUN cycle 10.
    @(negedge clock);
    opValid = 1'b1; op = 3'd0; data1 = 32'd5; data2 = 32'd6;
    @(negedge clock);
    opValid = 1'b0;
    repeat (9) @(negedge clock);
    flush = 1'b1;
    @(negedge clock);
    flush = 1'b0;
    chk("flush_busy", {31'd0, busy}, 32'd0);
    seen_done = done;
    repeat (3) begin
      @(negedge clock);
      seen_done = seen_done | done;
    end
    chk("flush_no_done", {31'd0, seen_done}, 32'd0);
    chk("flush_hi", hi, 32'h0000AAAA);
    chk("flush_lo", lo, 32'd12);

    @(negedge clock);
    opValid = 1'b1; op = 3'd5; data1 = 32'h5555; flush = 1'b1;
    @(negedge clock);
    opValid = 1'b0; flush = 1'b0;
    chk("flush_mtlo", lo, 32'd12);

    do_mt(3'd5, 32'h77);
    opValid = 1'b1; op = 3'd7;
    #1;
    chk("mflo_after_mt", result, 32'h77);
    chk("mflo_stall", {31'd0, stall}, 32'd0);
    opValid = 1'b0;

    // Asynchronous reset in the middle of a MULTU.
    @(negedge clock);
    opValid = 1'b1; op = 3'd1; data1 = 32'd9; data2 = 32'd9;
    @(negedge clock);
    opValid = 1'b0;
    repeat (4) @(negedge clock);
    #2 resetN = 1'b0;
    #1;
    chk("rstrun_hi", hi, 32'd0);
    chk("rstrun_lo", lo, 32'd0);
    chk("rstrun_busy", {31'd0, busy}, 32'd0);
    chk("rstrun_done", {31'd0, done}, 32'd0);
    @(negedge clock);
    resetN = 1'b1;
    do_mt(3'd5, 32'h1234);
    chk("rst_mtlo", lo, 32'h1234);
    chk("rst_mtlo_busy", {31'd0, busy}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
